// File: rtl/system_widths_pkg.sv
// Shared widths, defaults and state encoding for the instruction dispatch slice.
// No logic beyond a saturating-increment helper used by the retirement counters.
package system_widths_pkg;

  localparam int DISPATCH_DEPTH   = 8;
  localparam int DISPATCH_TIMEOUT = 255;
  localparam int INSTR_W          = 32;
  localparam int CNT_W            = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_HALT      = 2'd2
  } dispatch_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction queue; head is visible combinationally, push/pop take effect on the clock edge.
// Push is ignored when full and pop when empty; no bypass in either direction.
module instr_fifo
  import system_widths_pkg::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH,
  parameter int WIDTH = INSTR_W
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head_dat,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage is never reset; an empty queue presents zero instead of stale data.
  assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_dispatch.sv
// Queues host instructions and issues one at a time to the instruction unit, waiting for retirement under a watchdog.
// Issue pulse lands the cycle after an IDLE pop; the host is held off only when the queue is full.
module instruction_dispatch
  import system_widths_pkg::*;
#(
  parameter int DEPTH   = DISPATCH_DEPTH,
  parameter int TIMEOUT = DISPATCH_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   in_valid,
  input  logic [INSTR_W-1:0]     in_instr,
  output logic                   in_ready,
  output logic                   instr_valid,
  output logic [INSTR_W-1:0]     instr_in,
  input  logic                   core_ready_flag,
  input  logic                   instruction_done_flag,
  input  logic                   illegal_opcode_flag,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic [CNT_W-1:0]       retired_count,
  output logic [CNT_W-1:0]       illegal_count,
  output logic                   timeout_flag,
  output logic                   dispatch_busy
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  dispatch_state_t    r_state;
  logic [WD_W-1:0]    r_wd;
  logic               r_instr_valid;
  logic [INSTR_W-1:0] r_instr_in;
  logic [CNT_W-1:0]   r_retired;
  logic [CNT_W-1:0]   r_illegal;
  logic               r_timeout;

  logic               w_push;
  logic               w_pop;
  logic [INSTR_W-1:0] w_head;

  assign in_ready = !fifo_full;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == ST_IDLE) && !fifo_empty && core_ready_flag;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk        (clk),
    .resetN     (resetN),
    .i_push     (w_push),
    .i_push_dat (in_instr),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (fifo_count),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= ST_IDLE;
      r_wd          <= '0;
      r_instr_valid <= 1'b0;
      r_instr_in    <= '0;
      r_retired     <= '0;
      r_illegal     <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_instr_in    <= w_head;
            r_instr_valid <= 1'b1;
            r_wd          <= '0;
            r_state       <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          // Retirement wins over a watchdog expiry in the same cycle.
          if (instruction_done_flag) begin
            r_retired <= sat_inc(r_retired);
            if (illegal_opcode_flag) r_illegal <= sat_inc(r_illegal);
            r_state <= ST_IDLE;
          end else if (r_wd == WD_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_HALT;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instr_valid   = r_instr_valid;
  assign instr_in      = r_instr_in;
  assign retired_count = r_retired;
  assign illegal_count = r_illegal;
  assign timeout_flag  = r_timeout;
  assign dispatch_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_instruction_dispatch.sv
// Directed bench for instruction_dispatch: queue-based reference model checked every cycle, plus literal checks.
// Includes a simple instruction-unit responder with programmable retire delay.
module tb_instruction_dispatch;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 255;
  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_HALT = 2;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic        core_ready_flag = 1'b0;
  logic        instruction_done_flag;
  logic        illegal_opcode_flag;
  logic [3:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;
  logic [15:0] retired_count;
  logic [15:0] illegal_count;
  logic        timeout_flag;
  logic        dispatch_busy;

  logic iu_done = 1'b0;
  logic iu_ill = 1'b0;
  logic spur_done = 1'b0;
  logic spur_ill = 1'b0;
  bit   iu_en = 1'b0;
  int   iu_delay = 4;
  int   cyc = 0;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_q[$];
  int          m_phase = PH_IDLE;
  int          m_wait = 0;
  bit          m_vld = 1'b0;
  logic [31:0] m_instr = '0;
  logic [15:0] m_ret = '0;
  logic [15:0] m_ill = '0;
  bit          m_to = 1'b0;
  logic [31:0] issue_log[$];

  assign instruction_done_flag = iu_done || spur_done;
  assign illegal_opcode_flag   = (iu_done && iu_ill) || (spur_done && spur_ill);

  instruction_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk                   (clk),
    .resetN                (resetN),
    .in_valid              (in_valid),
    .in_instr              (in_instr),
    .in_ready              (in_ready),
    .instr_valid           (instr_valid),
    .instr_in              (instr_in),
    .core_ready_flag       (core_ready_flag),
    .instruction_done_flag (instruction_done_flag),
    .illegal_opcode_flag   (illegal_opcode_flag),
    .fifo_count            (fifo_count),
    .fifo_empty            (fifo_empty),
    .fifo_full             (fifo_full),
    .retired_count         (retired_count),
    .illegal_count         (illegal_count),
    .timeout_flag          (timeout_flag),
    .dispatch_busy         (dispatch_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // Reference behaviour: a queue of accepted words, one outstanding instruction, and a wait counter.
  task automatic model_step();
    bit acc;
    if (!resetN) begin
      m_q.delete();
      m_phase = PH_IDLE;
      m_wait  = 0;
      m_vld   = 1'b0;
      m_instr = '0;
      m_ret   = '0;
      m_ill   = '0;
      m_to    = 1'b0;
    end else begin
      acc   = in_valid && (m_q.size() < DEPTH);
      m_vld = 1'b0;
      case (m_phase)
        PH_IDLE: if (m_q.size() > 0 && core_ready_flag) begin
          m_instr = m_q.pop_front();
          m_vld   = 1'b1;
          m_wait  = 0;
          m_phase = PH_WAIT;
        end
        PH_WAIT: if (instruction_done_flag) begin
          if (m_ret != 16'hFFFF) m_ret++;
          if (illegal_opcode_flag && m_ill != 16'hFFFF) m_ill++;
          m_phase = PH_IDLE;
        end else begin
          m_wait++;
          if (m_wait >= TIMEOUT) begin
            m_to    = 1'b1;
            m_phase = PH_HALT;
          end
        end
        default: ;
      endcase
      if (acc) m_q.push_back(in_instr);
    end
  endtask

  task automatic compare_all();
    if (resetN) begin
      chk("in_ready",      32'(in_ready),      32'(m_q.size() < DEPTH));
      chk("fifo_count",    32'(fifo_count),    32'(m_q.size()));
      chk("fifo_empty",    32'(fifo_empty),    32'(m_q.size() == 0));
      chk("fifo_full",     32'(fifo_full),     32'(m_q.size() == DEPTH));
      chk("instr_valid",   32'(instr_valid),   32'(m_vld));
      chk("instr_in",      instr_in,           m_instr);
      chk("retired_count", 32'(retired_count), 32'(m_ret));
      chk("illegal_count", 32'(illegal_count), 32'(m_ill));
      chk("timeout_flag",  32'(timeout_flag),  32'(m_to));
      chk("dispatch_busy", 32'(dispatch_busy), 32'(m_phase != PH_IDLE));
      if (instr_valid) issue_log.push_back(instr_in);
    end
  endtask

  always @(posedge clk or negedge resetN) model_step();
  always @(negedge clk) compare_all();

  // Instruction-unit responder: retires each issued word iu_delay cycles after its issue pulse.
  always begin
    @(negedge clk);
    if (resetN && iu_en && instr_valid) begin
      iu_ill = (instr_in[31:28] == 4'hE);
      if (iu_delay > 0) begin
        repeat (iu_delay) @(posedge clk);
        #1;
      end
      iu_done = 1'b1;
      @(posedge clk);
      #1;
      iu_done = 1'b0;
      iu_ill  = 1'b0;
    end
  end

  function automatic logic [31:0] log_at(input int i);
    return (i < issue_log.size()) ? issue_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic push(input logic [31:0] w);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL push_accept word 0x%08h: in_ready never rose, required within 600 cycles", w);
    end
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < maxc && !ok; k++) begin
      @(negedge clk);
      if (fifo_empty && !dispatch_busy && !instr_valid) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle_%s: still busy after %0d cycles, required idle", nm, maxc);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 resetN = 1'b0;
    @(posedge clk);
    #2 resetN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t_iss;
    int t_to;
    bit seen;

    // Reset values before any clock edge.
    #1;
    chk("rst_fifo_count",  32'(fifo_count),    32'd0);
    chk("rst_fifo_empty",  32'(fifo_empty),    32'd1);
    chk("rst_in_ready",    32'(in_ready),      32'd1);
    chk("rst_instr_valid", 32'(instr_valid),   32'd0);
    chk("rst_busy",        32'(dispatch_busy), 32'd0);
    chk("rst_timeout",     32'(timeout_flag),  32'd0);
    #6 resetN = 1'b1;
    @(posedge clk);
    #1;

    // Three words, retired four cycles after each issue.
    core_ready_flag = 1'b1;
    iu_en = 1'b1;
    iu_delay = 4;
    issue_log.delete();
    push(32'h1000_0000);
    push(32'h2000_0000);
    push(32'h3000_0000);
    wait_idle(200, "three");
    chk("three_retired", 32'(retired_count), 32'd3);
    chk("three_issues",  32'(issue_log.size()), 32'd3);
    chk("three_word0",   log_at(0), 32'h1000_0000);
    chk("three_word1",   log_at(1), 32'h2000_0000);
    chk("three_word2",   log_at(2), 32'h3000_0000);

    // Illegal opcode retirement, then stray done pulses while idle.
    apply_reset();
    iu_delay = 2;
    push(32'hE000_0000);
    wait_idle(100, "illegal");
    chk("illegal_cnt",  32'(illegal_count), 32'd1);
    chk("illegal_ret",  32'(retired_count), 32'd1);
    spur_done = 1'b1;
    spur_ill  = 1'b1;
    @(posedge clk);
    #1;
    spur_done = 1'b0;
    spur_ill  = 1'b0;
    @(negedge clk);
    chk("idle_done_ret", 32'(retired_count), 32'd1);
    chk("idle_done_ill", 32'(illegal_count), 32'd1);
    @(posedge clk);
    #1;

    // Fill to full with the unit not ready, then release it.
    apply_reset();
    core_ready_flag = 1'b0;
    iu_delay = 1;
    issue_log.delete();
    for (int i = 0; i < 8; i++) push(32'h0100_0000 + i);
    in_valid = 1'b1;
    in_instr = 32'h0100_0008;
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready),   32'd0);
    chk("full_count",    32'(fifo_count), 32'd8);
    chk("full_flag",     32'(fifo_full),  32'd1);
    @(posedge clk);
    #1 core_ready_flag = 1'b1;
    @(negedge clk);
    chk("full_pop_no_bypass", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ninth_issue",    32'(instr_valid), 32'd1);
    chk("ninth_count",    32'(fifo_count),  32'd7);
    chk("ninth_in_ready", 32'(in_ready),    32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ninth_accepted", 32'(fifo_count), 32'd8);
    @(posedge clk);
    #1;
    wait_idle(200, "full");
    chk("full_retired", 32'(retired_count), 32'd9);
    chk("full_first",   log_at(0), 32'h0100_0000);
    chk("full_last",    log_at(8), 32'h0100_0008);

    // Asynchronous reset while waiting for retirement with four entries queued.
    core_ready_flag = 1'b0;
    iu_en = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h0200_0000 + i);
    core_ready_flag = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (instr_valid) seen = 1'b1;
    end
    chk("pre_rst_issue", 32'(seen),       32'd1);
    chk("pre_rst_count", 32'(fifo_count), 32'd4);
    #2 resetN = 1'b0;
    #1;
    chk("arst_count",   32'(fifo_count),    32'd0);
    chk("arst_valid",   32'(instr_valid),   32'd0);
    chk("arst_retired", 32'(retired_count), 32'd0);
    chk("arst_illegal", 32'(illegal_count), 32'd0);
    chk("arst_busy",    32'(dispatch_busy), 32'd0);
    @(posedge clk);
    #2 resetN = 1'b1;
    @(posedge clk);
    #1;

    // Retirement on the last permitted wait cycle beats the watchdog.
    iu_en = 1'b1;
    iu_delay = TIMEOUT - 1;
    push(32'h4000_0000);
    wait_idle(600, "edge");
    chk("edge_retired", 32'(retired_count), 32'd1);
    chk("edge_timeout", 32'(timeout_flag),  32'd0);

    // Watchdog expiry: halt, no more issues, queue still fills.
    apply_reset();
    iu_en = 1'b0;
    push(32'h5000_0000);
    t_iss = -1;
    t_to  = -1;
    for (int k = 0; k < 400 && t_to < 0; k++) begin
      @(negedge clk);
      if (instr_valid && t_iss < 0) t_iss = cyc;
      if (timeout_flag) t_to = cyc;
    end
    chk("wd_latency", 32'(t_to - t_iss), 32'd255);
    chk("wd_flag",    32'(timeout_flag), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push(32'h6000_0000 + i);
    @(negedge clk);
    chk("halt_count",    32'(fifo_count),    32'd8);
    chk("halt_full",     32'(fifo_full),     32'd1);
    chk("halt_busy",     32'(dispatch_busy), 32'd1);
    @(posedge clk);
    #1 spur_done = 1'b1;
    @(posedge clk);
    #1 spur_done = 1'b0;
    @(negedge clk);
    chk("halt_done_ignored", 32'(retired_count), 32'd0);
    @(posedge clk);
    #1;

    // Twenty words with immediate retirement: pointer wrap and ordering.
    apply_reset();
    iu_en = 1'b1;
    iu_delay = 0;
    issue_log.delete();
    for (int i = 0; i < 20; i++) push(32'hA000_0000 + i);
    wait_idle(300, "stream");
    chk("stream_retired", 32'(retired_count), 32'd20);
    chk("stream_issues",  32'(issue_log.size()), 32'd20);
    for (int i = 0; i < 20; i++) chk("stream_order", log_at(i), 32'hA000_0000 + i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_dispatch.md
INSTRUCTION_DISPATCH -- requirements
Module: instruction_dispatch

Interface
REQ-001 Parameter DEPTH, default 8, instruction FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 255, maximum cycles allowed in WAIT_DONE.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 resetN  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  host offers an instruction.
REQ-006 in_instr  input  32  host instruction word.
REQ-007 in_ready  output  1  FIFO can accept; equals !fifo_full (combinational).
REQ-008 instr_valid  output  1  registered one-cycle issue pulse to the instruction unit.
REQ-009 instr_in  output  32  registered instruction word, stable from the issue pulse until the next issue.
REQ-010 core_ready_flag  input  1  instruction unit idle.
REQ-011 instruction_done_flag  input  1  instruction unit retire pulse.
REQ-012 illegal_opcode_flag  input  1  coincident with the done pulse for a reserved opcode.
REQ-013 fifo_count  output  $clog2(DEPTH)+1  entries held.
REQ-014 fifo_empty / fifo_full  output  1 each  count==0 / count==DEPTH.
REQ-015 retired_count  output  16  retired instructions, saturating.
REQ-016 illegal_count  output  16  retired illegal instructions, saturating.
REQ-017 timeout_flag  output  1  sticky watchdog error.
REQ-018 dispatch_busy  output  1  high when state != IDLE.

Function
REQ-019 Push occurs when in_valid && in_ready: word written at the write pointer, which then advances modulo DEPTH.
REQ-020 A word pushed into an empty FIFO is not bypassed; it can issue no earlier than the following cycle.
REQ-021 FSM states: IDLE, WAIT_DONE, HALT.
REQ-022 IDLE: if !fifo_empty && core_ready_flag, pop the head, load instr_in, set instr_valid<=1, go to WAIT_DONE; otherwise hold.
REQ-023 instr_valid is high for exactly one cycle per popped entry and is never high outside the cycle after an IDLE pop.
REQ-024 WAIT_DONE: on instruction_done_flag, increment retired_count, increment illegal_count if illegal_opcode_flag, and return to IDLE.
REQ-025 Back-to-back throughput: done at cycle t -> IDLE at t+1 -> next instr_valid at t+2.
REQ-026 Done or illegal pulses seen in IDLE or HALT are ignored; counters do not change.
REQ-027 Watchdog: a counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle without done.
REQ-028 When the watchdog reaches TIMEOUT without done, timeout_flag<=1 and the FSM goes to HALT.
REQ-029 A done pulse in the same cycle the watchdog reaches TIMEOUT counts as retirement and no timeout occurs.
REQ-030 HALT: no further pops or issues; FIFO still accepts pushes until full; exit only via reset.
REQ-031 Simultaneous push and pop in one cycle: both occur and fifo_count is unchanged.
REQ-032 When full, in_ready=0 even if a pop occurs in that cycle; there is no full-bypass.
REQ-033 Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
REQ-034 retired_count and illegal_count saturate at 16'hFFFF and do not wrap.

Reset
REQ-035 resetN low asynchronously forces: state=IDLE, pointers=0, fifo_count=0, instr_valid=0, instr_in=0, both counters=0, watchdog=0, timeout_flag=0.
REQ-036 Reset mid-operation discards FIFO contents and any in-flight instruction, with no retirement counted.
REQ-037 FIFO storage array needs no reset; outputs derived from it are masked by count.

Structure
REQ-038 The dispatch_state_t enum and the DISPATCH_DEPTH and DISPATCH_TIMEOUT defaults go in system_widths_pkg.
REQ-039 The FIFO is a sub-module, instr_fifo (push/pop/count/full/empty), instantiated once.
REQ-040 The top level contains the FSM, watchdog and counters.

Verification
REQ-041 Push 3 words (0x10000000, 0x20000000, 0x30000000) with the IU model done 4 cycles after each issue -> 3 single-cycle instr_valid pulses in order; retired_count=3.
REQ-042 Push 9 words with core_ready_flag=0 and DEPTH=8 -> in_ready=0 after the 8th push, fifo_count=8, fifo_full=1; raise core_ready -> the 9th word is accepted the cycle after the first pop.
REQ-043 Done with illegal_opcode_flag=1 for instruction 0xE0000000 -> illegal_count=1, retired_count=1.
REQ-044 Issue with no done (TIMEOUT=255) -> timeout_flag=1 after 255 WAIT_DONE cycles; no further instr_valid; later pushes fill the FIFO.
REQ-045 Assert resetN low while in WAIT_DONE with 4 entries queued -> fifo_count=0, instr_valid=0, counters=0 immediately, without waiting for a clock edge.
REQ-046 Push 20 words with continuous issue -> pointer wrap-around exercised; words issued in exact push order; simultaneous push/pop holds count steady.
